// File: rtl/mult_pkg.sv
// Shared definitions for the integer multiply pipeline stages.
package mult_pkg;

    localparam int unsigned OPER_W    = 32;
    localparam int unsigned PROD_W    = 64;
    localparam int unsigned REGDEST_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Unsigned magnitude of a two's complement operand; |0x80000000| = 0x80000000.
    function automatic logic [OPER_W-1:0] mag(input logic [OPER_W-1:0] x);
        return x[OPER_W-1] ? OPER_W'(~x + OPER_W'(1)) : x;
    endfunction

endpackage

// File: rtl/mult_iter_stage1_if.sv
// Request bus from the classification stage and result bus to the next stage.
interface mult_iter_stage1_if;
    import mult_pkg::*;

    logic                 m0_m1_oper;
    logic [OPER_W-1:0]    m0_m1_rega;
    logic [OPER_W-1:0]    m0_m1_regb;
    logic [REGDEST_W-1:0] m0_m1_regdest;
    logic                 m0_m1_ispositive;
    logic                 m0_m1_iszero;
    logic                 m1_m0_stall;
    logic                 m1_m2_oper;
    logic [REGDEST_W-1:0] m1_m2_regdest;
    logic [OPER_W-1:0]    m1_m2_lo;
    logic [OPER_W-1:0]    m1_m2_hi;

    modport master (
        output m0_m1_oper, m0_m1_rega, m0_m1_regb, m0_m1_regdest,
               m0_m1_ispositive, m0_m1_iszero,
        input  m1_m0_stall, m1_m2_oper, m1_m2_regdest, m1_m2_lo, m1_m2_hi
    );

    modport slave (
        input  m0_m1_oper, m0_m1_rega, m0_m1_regb, m0_m1_regdest,
               m0_m1_ispositive, m0_m1_iszero,
        output m1_m0_stall, m1_m2_oper, m1_m2_regdest, m1_m2_lo, m1_m2_hi
    );

endinterface

// File: rtl/mult_step.sv
// One shift-add iteration: adds mcand times the retired multiplier bits into acc.
module mult_step
    import mult_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [PROD_W-1:0]         mcand,
    input  logic [BITS_PER_CYCLE-1:0] bits,
    input  logic [PROD_W-1:0]         acc,
    output logic [PROD_W-1:0]         acc_next_c
);

    assign acc_next_c = acc + (mcand * PROD_W'(bits));

endmodule

// File: rtl/mult_iter_stage1.sv
// Iterative shift-add signed multiplier stage; stalls upstream while iterating.
// Optional MULT1_EARLY_EXIT_EN finishes as soon as the remaining multiplier is zero.
module mult_iter_stage1
    import mult_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic               clock,
    input  logic               reset,
    mult_iter_stage1_if.slave  bus
);

    localparam int unsigned N     = OPER_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = 5;

    state_t               state, state_d;
    logic [PROD_W-1:0]    mcand, mcand_d;
    logic [OPER_W-1:0]    mplier, mplier_d;
    logic [PROD_W-1:0]    acc, acc_d;
    logic                 sign, sign_d;
    logic [REGDEST_W-1:0] dest, dest_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic                 out_oper, out_oper_d;
    logic [REGDEST_W-1:0] out_dest, out_dest_d;
    logic [OPER_W-1:0]    out_lo, out_lo_d;
    logic [OPER_W-1:0]    out_hi, out_hi_d;
    logic [PROD_W-1:0]    acc_step;
    logic [PROD_W-1:0]    prod;
    logic                 finish;

    mult_step #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .mcand      (mcand),
        .bits       (mplier[BITS_PER_CYCLE-1:0]),
        .acc        (acc),
        .acc_next_c (acc_step)
    );

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            sign     <= 1'b0;
            dest     <= '0;
            cnt      <= '0;
            out_oper <= 1'b0;
            out_dest <= '0;
            out_lo   <= '0;
            out_hi   <= '0;
        end else begin
            state    <= state_d;
            mcand    <= mcand_d;
            mplier   <= mplier_d;
            acc      <= acc_d;
            sign     <= sign_d;
            dest     <= dest_d;
            cnt      <= cnt_d;
            out_oper <= out_oper_d;
            out_dest <= out_dest_d;
            out_lo   <= out_lo_d;
            out_hi   <= out_hi_d;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state;
        mcand_d    = mcand;
        mplier_d   = mplier;
        acc_d      = acc;
        sign_d     = sign;
        dest_d     = dest;
        cnt_d      = cnt;
        out_oper_d = 1'b0;
        out_dest_d = '0;
        out_lo_d   = '0;
        out_hi_d   = '0;
        prod       = '0;
        finish     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.m0_m1_oper) begin
                    if (bus.m0_m1_iszero) begin
                        out_oper_d = 1'b1;
                        out_dest_d = bus.m0_m1_regdest;
                    end else begin
                        mcand_d  = PROD_W'(mag(bus.m0_m1_rega));
                        mplier_d = mag(bus.m0_m1_regb);
                        acc_d    = '0;
                        sign_d   = bus.m0_m1_ispositive;
                        dest_d   = bus.m0_m1_regdest;
                        cnt_d    = '0;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand << BITS_PER_CYCLE;
                mplier_d = mplier >> BITS_PER_CYCLE;
                cnt_d    = CNT_W'(cnt + CNT_W'(1));
`ifdef MULT1_EARLY_EXIT_EN
                finish   = (cnt == CNT_W'(N - 1)) || (mplier_d == '0);
`else
                finish   = (cnt == CNT_W'(N - 1));
`endif
                if (finish) begin
                    prod       = sign ? acc_step : PROD_W'(~acc_step + PROD_W'(1));
                    out_oper_d = 1'b1;
                    out_dest_d = dest;
                    out_lo_d   = prod[OPER_W-1:0];
                    out_hi_d   = prod[PROD_W-1:OPER_W];
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m1_m0_stall   = (state == BUSY);
    assign bus.m1_m2_oper    = out_oper;
    assign bus.m1_m2_regdest = out_dest;
    assign bus.m1_m2_lo      = out_lo;
    assign bus.m1_m2_hi      = out_hi;

endmodule

// File: doc/mult_iter_stage1.md
# mult_iter_stage1

Second stage of the integer multiply pipeline, directly downstream of the operand-classification stage. It consumes the classified operands (oper, two 32-bit operands, destination register, sign flag, zero flag) and computes the 64-bit signed product. The product is built with an iterative shift-add over unsigned magnitudes, then sign-corrected. It holds the upstream stage with a stall signal while iterating, and emits a single-cycle result strobe to the next stage.

## Interface
- BITS_PER_CYCLE, 1: multiplier bits retired per iteration; legal values 1, 2, 4, 8; iteration count N = 32/BITS_PER_CYCLE
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clock only
- m0_m1_oper  in  1  valid multiply request from upstream
- m0_m1_rega  in  32  operand A, two's complement
- m0_m1_regb  in  32  operand B, two's complement; its magnitude is the multiplier
- m0_m1_regdest  in  5  destination register index
- m0_m1_ispositive  in  1  1 = product non-negative, 0 = product negative
- m0_m1_iszero  in  1  1 = at least one operand is zero
- m1_m0_stall  out  1  upstream must hold all m0_m1_* inputs while high
- m1_m2_oper  out  1  result-valid strobe, one cycle per accepted request
- m1_m2_regdest  out  5  destination of the result
- m1_m2_lo  out  32  product bits [31:0]
- m1_m2_hi  out  32  product bits [63:32]

## Operation
- States: IDLE, BUSY.
- Reset (reset==0 at posedge) has priority over everything. State goes to IDLE; all outputs become 0; internal registers are cleared. Any in-flight operation is discarded and no strobe is issued.
- IDLE, m0_m1_oper=0: outputs driven to 0 next cycle; state stays IDLE.
- IDLE, oper=1, iszero=1 (zero path):
  - next cycle m1_m2_oper=1, lo=hi=0, regdest copied
  - state stays IDLE; stall never asserts
- IDLE, oper=1, iszero=0 (accept):
  - mcand (64-bit) loaded with zero-extended |rega|
  - mplier (32-bit) loaded with |regb|
  - acc=0; sign latched from ispositive; regdest latched; counter=0
  - state goes to BUSY; m1_m2_oper=0
- Magnitude rule: |x| = x if x[31]==0, else (~x+1) treated as unsigned 32-bit. |0x80000000| = 0x80000000.
- BUSY, each cycle:
  - acc += mcand * mplier[BITS_PER_CYCLE-1:0], mod 2^64
  - mcand <<= BITS_PER_CYCLE; mplier >>= BITS_PER_CYCLE; counter++
  - The accumulator does not shift, so result alignment is independent of the number of iterations.
- Finish: on the edge where counter reaches N-1 (or early-exit condition, see Configuration):
  - the final acc value is negated as 64-bit two's complement if sign==0
  - the value is written to {hi,lo}; m1_m2_oper=1, regdest=latched value
  - state goes to IDLE
- Inputs are ignored in BUSY.
- m1_m2_oper is 0 in every cycle except a finish or zero-path cycle. Data outputs are 0 whenever oper is 0.

## Timing
- m1_m0_stall = (state==BUSY), decoded from the state register; no combinational path from inputs.
- Zero path: latency 1 cycle; throughput 1 per cycle.
- Iterative path:
  - accept at edge k; strobe visible after edge k+N; stall high for the N cycles between those edges
  - the next request is accepted no earlier than edge k+N+1, giving throughput 1 per N+1 cycles
- Back-to-back zero-path requests produce consecutive strobes.
- A request presented during the finish cycle is held by upstream and accepted on the following edge.

## Configuration
- MULT1_EARLY_EXIT_EN
- Defined: BUSY also finishes on the first edge where the post-shift mplier equals 0, so latency becomes ceil(bitlen(|regb|)/BITS_PER_CYCLE) cycles, with a minimum of 1. Results are identical to the undefined case.
- Undefined: latency is always exactly N cycles.

## Structure
- Shared package mult_pkg holds:
  - state enum (IDLE, BUSY)
  - width constants: operand 32, product 64, regdest 5
  - magnitude function used by both multiply stages
- One sub-module, mult_step: combinational; takes mcand, the mplier low bits and acc; returns the next acc. It is instanced once.

## Test plan
- BITS_PER_CYCLE=1, no early exit:
  - 3 * 5 -> stall high for 32 cycles; strobe with hi=0x00000000, lo=0x0000000F, regdest preserved
  - -7 * 6 (ispositive=0) -> hi=0xFFFFFFFF, lo=0xFFFFFFD6
- 0x80000000 * 0x80000000 (ispositive=1) -> hi=0x40000000, lo=0x00000000; also with BITS_PER_CYCLE=4, latency 8.
- iszero=1 requests on 3 consecutive cycles (regdest 1,2,3) -> 3 consecutive strobes, data 0, stall never high.
- Assert reset for 1 cycle at iteration 10 of 12345 * 678 -> all outputs 0, no strobe, IDLE. A following request 2 * 2 returns lo=4.
- MULT1_EARLY_EXIT_EN, BITS_PER_CYCLE=1:
  - 3 * 5 -> strobe after 3 cycles, lo=15
  - 1 * 0xFFFFFFFF (ispositive=0, result -1) -> 1 cycle, hi=lo=0xFFFFFFFF
